// File: rtl/matmul_bram_loader_pkg.sv
// Shared definitions for the matmul BRAM loader: default geometry and FSM encoding.
package matmul_bram_loader_pkg;

  localparam int unsigned MM_DWIDTH       = 8;   // bits per matrix element
  localparam int unsigned MM_SIZE         = 8;   // elements (byte lanes) per BRAM word
  localparam int unsigned MM_AWIDTH       = 16;  // BRAM address width
  localparam int unsigned MM_STRIDE_WIDTH = 16;  // row stride width
  localparam int unsigned MM_ROWS_WIDTH   = 8;   // row count width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/matmul_lane_mask.sv
// Combinational lane zeroing: lane i of data_i passes when mask_i[i]=1, else 0.
// Ports:
//   data_i  : MAT_MUL_SIZE*DWIDTH input word
//   mask_i  : per-lane keep mask
//   data_c  : masked word (combinational)
module matmul_lane_mask
  import matmul_bram_loader_pkg::*;
#(
  parameter int unsigned DWIDTH       = MM_DWIDTH,
  parameter int unsigned MAT_MUL_SIZE = MM_SIZE
) (
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_i,
  input  logic [MAT_MUL_SIZE-1:0]        mask_i,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_c
);

  // Per-lane select between the input lane and zero.
  always_comb begin
    data_c = '0;
    for (int unsigned i = 0; i < MAT_MUL_SIZE; i++) begin
      if (mask_i[i]) begin
        data_c[i*DWIDTH +: DWIDTH] = data_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

endmodule

// File: rtl/matmul_bram_loader.sv
// Loads num_rows stream beats into BRAM at base_addr + k*addr_stride,
// zeroing masked lanes, and reports busy/done/err_len status.
// Ports:
//   clk, resetn                 : clock, async active-low reset
//   start, clear_done           : load request pulse, status clear
//   base_addr, addr_stride      : first row address, per-row increment
//   num_rows, validity_mask_cols: row count (0 legal), lane keep mask
//   s_valid/s_ready/s_data/s_last : row stream
//   bram_addr_ext/wdata_ext/we_ext: BRAM external write port (registered)
//   busy, done, err_len         : status (registered)
module matmul_bram_loader
  import matmul_bram_loader_pkg::*;
#(
  parameter int unsigned DWIDTH            = MM_DWIDTH,
  parameter int unsigned MAT_MUL_SIZE      = MM_SIZE,
  parameter int unsigned AWIDTH            = MM_AWIDTH,
  parameter int unsigned ADDR_STRIDE_WIDTH = MM_STRIDE_WIDTH
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [ADDR_STRIDE_WIDTH-1:0]   addr_stride,
  input  logic [MM_ROWS_WIDTH-1:0]       num_rows,
  input  logic [MAT_MUL_SIZE-1:0]        validity_mask_cols,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] s_data,
  input  logic                           s_last,
  output logic [AWIDTH-1:0]              bram_addr_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_ext,
  output logic [MAT_MUL_SIZE-1:0]        bram_we_ext,
  output logic                           busy,
  output logic                           done,
  output logic                           err_len,
  input  logic                           clear_done
);

  localparam int unsigned WW = MAT_MUL_SIZE * DWIDTH;
  localparam int unsigned RW = MM_ROWS_WIDTH;

  state_e                       state_q,     state_d;
  logic                         s_ready_q,   s_ready_d;
  logic [AWIDTH-1:0]            addr_q,      addr_d;
  logic [WW-1:0]                wdata_q,     wdata_d;
  logic [MAT_MUL_SIZE-1:0]      we_q,        we_d;
  logic                         busy_q,      busy_d;
  logic                         done_q,      done_d;
  logic                         err_q,       err_d;
  logic [AWIDTH-1:0]            cur_addr_q,  cur_addr_d;
  logic [ADDR_STRIDE_WIDTH-1:0] stride_q,    stride_d;
  logic [RW-1:0]                rows_q,      rows_d;
  logic [RW-1:0]                rows_done_q, rows_done_d;
  logic [MAT_MUL_SIZE-1:0]      mask_q,      mask_d;

  logic [WW-1:0] masked_c;
  logic          accept_c;
  logic          last_row_c;

  // Lane zeroing uses the mask latched at start, not the live input.
  matmul_lane_mask #(
    .DWIDTH       (DWIDTH),
    .MAT_MUL_SIZE (MAT_MUL_SIZE)
  ) u_lane_mask (
    .data_i (s_data),
    .mask_i (mask_q),
    .data_c (masked_c)
  );

  // s_ready_q is high exactly while in LOAD.
  assign accept_c   = s_valid && s_ready_q;
  assign last_row_c = (rows_done_q == (rows_q - RW'(1)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = '0;
    done_d      = done_q;
    err_d       = err_q;
    cur_addr_d  = cur_addr_q;
    stride_d    = stride_q;
    rows_d      = rows_q;
    rows_done_d = rows_done_q;
    mask_d      = mask_q;

    if (clear_done) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (num_rows != '0) begin
            cur_addr_d  = base_addr;
            stride_d    = addr_stride;
            rows_d      = num_rows;
            mask_d      = validity_mask_cols;
            rows_done_d = '0;
            state_d     = ST_LOAD;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          addr_d      = cur_addr_q;
          wdata_d     = masked_c;
          we_d        = '1;
          // Address arithmetic wraps modulo 2^AWIDTH.
          cur_addr_d  = cur_addr_q + AWIDTH'(stride_q);
          rows_done_d = rows_done_q + RW'(1);
          if (last_row_c) begin
            state_d = ST_FIN;
            if (!s_last) err_d = 1'b1;
          end else if (s_last) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_addr_q  <= '0;
      stride_q    <= '0;
      rows_q      <= '0;
      rows_done_q <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cur_addr_q  <= cur_addr_d;
      stride_q    <= stride_d;
      rows_q      <= rows_d;
      rows_done_q <= rows_done_d;
      mask_q      <= mask_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign bram_addr_ext  = addr_q;
  assign bram_wdata_ext = wdata_q;
  assign bram_we_ext    = we_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_len        = err_q;

endmodule

// File: tb/tb_matmul_bram_loader.sv
// Directed self-checking bench for matmul_bram_loader (default parameters).
module tb_matmul_bram_loader;

  logic        clk, resetn, start, clear_done;
  logic [15:0] base_addr, addr_stride;
  logic [7:0]  num_rows, validity_mask_cols;
  logic        s_valid, s_ready, s_last;
  logic [63:0] s_data;
  logic [15:0] bram_addr_ext;
  logic [63:0] bram_wdata_ext;
  logic [7:0]  bram_we_ext;
  logic        busy, done, err_len;

  matmul_bram_loader dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .addr_stride(addr_stride), .num_rows(num_rows),
    .validity_mask_cols(validity_mask_cols), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .bram_addr_ext(bram_addr_ext), .bram_wdata_ext(bram_wdata_ext),
    .bram_we_ext(bram_we_ext), .busy(busy), .done(done),
    .err_len(err_len), .clear_done(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_fn(input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Write scoreboard: predicts each write from observed acceptances.
  logic [15:0] exp_addr_m, stride_m;
  logic [7:0]  mask_m;
  logic        pend = 1'b0;
  logic [15:0] pend_addr, last_addr;
  logic [63:0] pend_data, first_data;
  int          n_writes = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      pend = 1'b0;
      chk("we_in_reset", 64'(bram_we_ext), 64'h0);
    end else begin
      if (pend) begin
        chk("we_after_accept", 64'(bram_we_ext), 64'hFF);
        chk("wr_addr", 64'(bram_addr_ext), 64'(pend_addr));
        chk("wr_data", bram_wdata_ext, pend_data);
        if (n_writes == 0) first_data = bram_wdata_ext;
        last_addr = bram_addr_ext;
        n_writes++;
      end else if (bram_we_ext != 8'h0) begin
        chk("unexpected_we", 64'(bram_we_ext), 64'h0);
      end
      pend = s_valid && s_ready;
      if (pend) begin
        pend_addr  = exp_addr_m;
        pend_data  = mask_fn(s_data, mask_m);
        exp_addr_m = exp_addr_m + stride_m;
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [15:0] st,
                          input logic [7:0] r, input logic [7:0] m);
    @(posedge clk); #1;
    base_addr = b; addr_stride = st; num_rows = r; validity_mask_cols = m;
    exp_addr_m = b; stride_m = st; mask_m = m; n_writes = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble config inputs: the DUT must use its latched copy.
    base_addr = 16'hDEAD; addr_stride = 16'h0777; num_rows = 8'd1; validity_mask_cols = 8'h00;
  endtask

  task automatic send(input int nb, input int last_at, input logic [63:0] d0,
                      input logic [7:0] gaps, input bit restart);
    bit acc;
    for (int b = 0; b < nb; b++) begin
      if (gaps[b]) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = d0 + 64'(b) * 64'h0101010101010101;
      s_last  = (b + 1 == last_at);
      if (restart && b == 1) begin
        start = 1'b1; base_addr = 16'h5555; num_rows = 8'd9;
      end
      acc = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        if (acc) break;
      end
      start = 1'b0;
      if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 64'(0), 64'(1));
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    logic [7:0]  rows;
    logic [7:0]  mask;
    logic [63:0] d0;
    int          nb;
    int          last_at;
    logic [7:0]  gaps;
    bit          restart;
    int          exp_writes;
    logic        exp_err;
    logic [63:0] exp_first;
    logic [15:0] exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h0000, 16'h0008, 8'd8, 8'hFF, 64'h0807060504030201, 8, 8, 8'h00, 1'b0,
                8, 1'b0, 64'h0807060504030201, 16'h0038};
    vecs[1] = '{16'h0100, 16'h0001, 8'd1, 8'h0F, 64'h1122334455667788, 1, 1, 8'h00, 1'b0,
                1, 1'b0, 64'h0000000055667788, 16'h0100};
    vecs[2] = '{16'h0040, 16'h0010, 8'd4, 8'h81, 64'hA0A0A0A0A0A0A0A0, 2, 2, 8'h00, 1'b0,
                2, 1'b1, 64'hA0000000000000A0, 16'h0050};
    vecs[3] = '{16'hFFF8, 16'h0008, 8'd3, 8'hF0, 64'hFFEEDDCCBBAA9988, 3, 3, 8'h00, 1'b0,
                3, 1'b0, 64'hFFEEDDCC00000000, 16'h0008};
    vecs[4] = '{16'h1000, 16'h0100, 8'd3, 8'h3C, 64'h0123456789ABCDEF, 3, 0, 8'h06, 1'b1,
                3, 1'b1, 64'h0000456789AB0000, 16'h1200};
    vecs[5] = '{16'h0200, 16'h0004, 8'd1, 8'hA5, 64'h1122334455667788, 1, 1, 8'h00, 1'b0,
                1, 1'b0, 64'h1100330000660088, 16'h0200};

    resetn = 1'b0; start = 1'b0; clear_done = 1'b0;
    base_addr = '0; addr_stride = '0; num_rows = '0; validity_mask_cols = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    exp_addr_m = '0; stride_m = '0; mask_m = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'h0);
    chk("rst_we", 64'(bram_we_ext), 64'h0);
    chk("rst_addr", 64'(bram_addr_ext), 64'h0);
    chk("rst_wdata", bram_wdata_ext, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_err", 64'(err_len), 64'h0);
    resetn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].base, vecs[v].stride, vecs[v].rows, vecs[v].mask);
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'h1);
      send(vecs[v].nb, vecs[v].last_at, vecs[v].d0, vecs[v].gaps, vecs[v].restart);
      wait_done();
      chk($sformatf("v%0d_writes", v), 64'(n_writes), 64'(vecs[v].exp_writes));
      chk($sformatf("v%0d_first_data", v), first_data, vecs[v].exp_first);
      chk($sformatf("v%0d_last_addr", v), 64'(last_addr), 64'(vecs[v].exp_last_addr));
      chk($sformatf("v%0d_done", v), 64'(done), 64'h1);
      chk($sformatf("v%0d_err", v), 64'(err_len), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_s_ready", v), 64'(s_ready), 64'h0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_sticky", v), 64'(done), 64'h1);
    end

    // Zero rows: FIN after the start edge, done one edge later, no write.
    @(posedge clk); #1;
    num_rows = 8'd0; start = 1'b1; n_writes = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("z_busy_fin", 64'(busy), 64'h1);
    chk("z_done_cleared", 64'(done), 64'h0);
    @(posedge clk); #1;
    chk("z_done", 64'(done), 64'h1);
    chk("z_busy_idle", 64'(busy), 64'h0);
    chk("z_writes", 64'(n_writes), 64'h0);

    // clear_done clears both flags.
    do_start(16'h0000, 16'h0001, 8'd2, 8'hFF);
    send(1, 1, 64'h0, 8'h00, 1'b0);
    wait_done();
    chk("cd_err_pre", 64'(err_len), 64'h1);
    @(posedge clk); #1; clear_done = 1'b1;
    @(posedge clk); #1; clear_done = 1'b0;
    chk("cd_done", 64'(done), 64'h0);
    chk("cd_err", 64'(err_len), 64'h0);

    // start and clear_done together: start wins, flags end at 0.
    do_start(16'h0000, 16'h0001, 8'd2, 8'hFF);
    send(1, 1, 64'h0, 8'h00, 1'b0);
    wait_done();
    @(posedge clk); #1;
    base_addr = 16'h0700; addr_stride = 16'h0001; num_rows = 8'd1; validity_mask_cols = 8'hFF;
    exp_addr_m = 16'h0700; stride_m = 16'h0001; mask_m = 8'hFF; n_writes = 0;
    start = 1'b1; clear_done = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear_done = 1'b0;
    chk("sc_done", 64'(done), 64'h0);
    chk("sc_err", 64'(err_len), 64'h0);
    chk("sc_busy", 64'(busy), 64'h1);
    send(1, 1, 64'h55AA55AA55AA55AA, 8'h00, 1'b0);
    wait_done();
    chk("sc_writes", 64'(n_writes), 64'h1);
    chk("sc_done_end", 64'(done), 64'h1);

    // Reset mid-load after 3 of 8 rows with s_valid held high.
    do_start(16'h0300, 16'h0020, 8'd8, 8'hFF);
    s_valid = 1'b1; s_data = 64'hCAFEF00DCAFEF00D; s_last = 1'b0;
    begin
      bit got3;
      got3 = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk); #1;
        if (n_writes >= 3) begin got3 = 1'b1; break; end
      end
      if (!got3) chk("mr_timeout", 64'(0), 64'(1));
    end
    resetn = 1'b0;
    #1;
    chk("mr_we", 64'(bram_we_ext), 64'h0);
    chk("mr_s_ready", 64'(s_ready), 64'h0);
    chk("mr_busy", 64'(busy), 64'h0);
    chk("mr_addr", 64'(bram_addr_ext), 64'h0);
    chk("mr_writes", 64'(n_writes), 64'h3);
    s_valid = 1'b0;
    @(negedge clk); #2;
    resetn = 1'b1;
    do_start(16'h0300, 16'h0020, 8'd8, 8'hFF);
    send(8, 8, 64'h1000000000000001, 8'h00, 1'b0);
    wait_done();
    chk("mr_clean_writes", 64'(n_writes), 64'h8);
    chk("mr_clean_last", 64'(last_addr), 64'h03E0);
    chk("mr_clean_done", 64'(done), 64'h1);
    chk("mr_clean_err", 64'(err_len), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
